// File: rtl/fmac_rx_fifo_wr_ctrl.sv
// RX data FIFO write controller: admits frames at start-of-frame, writes beats,
// truncates oversize frames and emits one length/status descriptor per admitted frame.
module fmac_rx_fifo_wr_ctrl #(
  parameter int unsigned DWIDTH    = 256,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned PTR       = 12,
  parameter int unsigned MAX_WORDS = 300,
  parameter int unsigned LEN_W     = 14
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic              in_err,
  input  logic [4:0]        in_nbytes,
  input  logic [DWIDTH-1:0] in_data,
  output logic              fifo_wrreq,
  output logic [DWIDTH-1:0] fifo_data,
  input  logic [PTR:0]      fifo_wrusedw,
  input  logic              fifo_wrfull,
  output logic              desc_wrreq,
  output logic [LEN_W+1:0]  desc_data,
  input  logic              desc_full,
  output logic [31:0]       stat_frames,
  output logic [31:0]       stat_drops
);

  localparam int unsigned CNT_W      = $clog2(MAX_WORDS + 1);
  localparam int unsigned BEAT_BYTES = DWIDTH / 8;
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int unsigned DESC_W     = LEN_W + 2;
  localparam int unsigned SUM_W      = PTR + 2;

  typedef enum logic [1:0] {IDLE, WRITE, DISCARD} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wcnt, wcnt_nxt;
  logic               err, err_nxt, trunc, trunc_nxt, drop, drop_nxt;
  logic               pend_v, pend_v_nxt;
  logic [DESC_W-1:0]  pend, pend_nxt;
  logic               wr_nxt, desc_v_nxt;
  logic [DWIDTH-1:0]  data_nxt;
  logic [DESC_W-1:0]  desc_nxt;
  logic [31:0]        frames_nxt, drops_nxt;

  logic [SUM_W-1:0]   fill_sum;
  logic               admit, err_acc;
  logic [LEN_W-1:0]   nb_eff, len_cnt;
  logic               a_v, b_v;
  logic [DESC_W-1:0]  a_desc, b_desc;
  logic [1:0]         frames_inc;
  logic               drop_inc;
  logic [32:0]        frames_sum, drops_sum;

  // Next-state, write strobe, descriptor and statistics decode
  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    err_nxt    = err;
    trunc_nxt  = trunc;
    drop_nxt   = drop;
    wr_nxt     = 1'b0;
    a_v        = 1'b0;
    a_desc     = '0;
    b_v        = 1'b0;
    b_desc     = '0;
    frames_inc = 2'd0;
    drop_inc   = 1'b0;
    err_acc    = err | in_err;

    fill_sum = SUM_W'(fifo_wrusedw) + SUM_W'(MAX_WORDS + 1);
    admit    = !desc_full && !fifo_wrfull && (fill_sum <= SUM_W'(DEPTH));
    nb_eff   = (in_nbytes == 5'd0) ? LEN_W'(BEAT_BYTES) : LEN_W'(in_nbytes);
    len_cnt  = LEN_W'(wcnt) << BEAT_SHIFT;

    if (in_valid && in_sop) begin
      // An open frame (written or truncated) is closed before the new sop is judged
      if (state == WRITE || (state == DISCARD && !drop)) begin
        a_v        = 1'b1;
        a_desc     = {1'b1, trunc, len_cnt};
        frames_inc = frames_inc + 2'd1;
      end
      trunc_nxt = 1'b0;
      if (admit) begin
        wr_nxt   = 1'b1;
        wcnt_nxt = CNT_W'(1);
        err_nxt  = in_err;
        drop_nxt = 1'b0;
        if (in_eop) begin
          b_v        = 1'b1;
          b_desc     = {in_err, 1'b0, nb_eff};
          frames_inc = frames_inc + 2'd1;
          state_nxt  = IDLE;
        end else begin
          state_nxt = WRITE;
        end
      end else begin
        drop_inc  = 1'b1;
        drop_nxt  = 1'b1;
        state_nxt = in_eop ? IDLE : DISCARD;
      end
    end else if (in_valid) begin
      case (state)
        WRITE: begin
          err_nxt = err_acc;
          if (wcnt < CNT_W'(MAX_WORDS)) begin
            wr_nxt   = 1'b1;
            wcnt_nxt = wcnt + CNT_W'(1);
            if (in_eop) begin
              a_v        = 1'b1;
              a_desc     = {err_acc, 1'b0, len_cnt + nb_eff};
              frames_inc = 2'd1;
              state_nxt  = IDLE;
            end
          end else begin
            trunc_nxt = 1'b1;
            drop_nxt  = 1'b0;
            if (in_eop) begin
              a_v        = 1'b1;
              a_desc     = {2'b11, LEN_W'(MAX_WORDS * BEAT_BYTES)};
              frames_inc = 2'd1;
              state_nxt  = IDLE;
            end else begin
              state_nxt = DISCARD;
            end
          end
        end
        DISCARD: begin
          if (in_eop) begin
            if (!drop) begin
              a_v        = 1'b1;
              a_desc     = {2'b11, LEN_W'(MAX_WORDS * BEAT_BYTES)};
              frames_inc = 2'd1;
            end
            state_nxt = IDLE;
          end
        end
        default: ;
      endcase
    end

    // A close plus a single-beat frame yields two descriptors; the second is held one cycle
    desc_v_nxt = pend_v | a_v | b_v;
    desc_nxt   = desc_data;
    pend_v_nxt = 1'b0;
    pend_nxt   = pend;
    if (pend_v) begin
      desc_nxt   = pend;
      pend_v_nxt = a_v | b_v;
      pend_nxt   = a_v ? a_desc : b_desc;
    end else if (a_v) begin
      desc_nxt   = a_desc;
      pend_v_nxt = b_v;
      pend_nxt   = b_desc;
    end else if (b_v) begin
      desc_nxt = b_desc;
    end

    data_nxt   = wr_nxt ? in_data : fifo_data;
    frames_sum = {1'b0, stat_frames} + 33'(frames_inc);
    drops_sum  = {1'b0, stat_drops} + 33'(drop_inc);
    frames_nxt = frames_sum[32] ? 32'hFFFF_FFFF : frames_sum[31:0];
    drops_nxt  = drops_sum[32] ? 32'hFFFF_FFFF : drops_sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= IDLE;
      wcnt        <= '0;
      err         <= 1'b0;
      trunc       <= 1'b0;
      drop        <= 1'b0;
      pend_v      <= 1'b0;
      pend        <= '0;
      fifo_wrreq  <= 1'b0;
      fifo_data   <= '0;
      desc_wrreq  <= 1'b0;
      desc_data   <= '0;
      stat_frames <= '0;
      stat_drops  <= '0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      err         <= err_nxt;
      trunc       <= trunc_nxt;
      drop        <= drop_nxt;
      pend_v      <= pend_v_nxt;
      pend        <= pend_nxt;
      fifo_wrreq  <= wr_nxt;
      fifo_data   <= data_nxt;
      desc_wrreq  <= desc_v_nxt;
      desc_data   <= desc_nxt;
      stat_frames <= frames_nxt;
      stat_drops  <= drops_nxt;
    end
  end

`ifndef SYNTHESIS
  // Admission headroom guarantees the data FIFO never fills mid-frame
  a_no_full_in_write: assert property (@(posedge clk) disable iff (srst)
    !(state == WRITE && fifo_wrfull));
`endif

endmodule

// File: tb/tb_fmac_rx_fifo_wr_ctrl.sv
// Directed bench for fmac_rx_fifo_wr_ctrl: latency, admission threshold, drops,
// truncation, missing-eop close and mid-frame reset.
module tb_fmac_rx_fifo_wr_ctrl;

  logic         clk = 1'b0;
  logic         srst = 1'b0;
  logic         in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0;
  logic [4:0]   in_nbytes = '0;
  logic [255:0] in_data = '0;
  logic         fifo_wrreq, fifo_wrfull = 1'b0, desc_wrreq, desc_full = 1'b0;
  logic [255:0] fifo_data;
  logic [12:0]  fifo_wrusedw = '0;
  logic [15:0]  desc_data;
  logic [31:0]  stat_frames, stat_drops;

  int vectors = 0;
  int miscompares = 0;
  int wr_total = 0;
  logic [15:0] descq[$];

  fmac_rx_fifo_wr_ctrl dut (
    .clk(clk), .srst(srst), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_err(in_err), .in_nbytes(in_nbytes), .in_data(in_data),
    .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .fifo_wrusedw(fifo_wrusedw),
    .fifo_wrfull(fifo_wrfull), .desc_wrreq(desc_wrreq), .desc_data(desc_data),
    .desc_full(desc_full), .stat_frames(stat_frames), .stat_drops(stat_drops)
  );

  always #5 clk = ~clk;

  // Outputs are sampled on the falling edge, half a cycle away from updates
  always @(negedge clk) begin
    if (fifo_wrreq) wr_total++;
    if (desc_wrreq) descq.push_back(desc_data);
  end

  function automatic logic [255:0] beat_data(input int k);
    return {32'(k) ^ 32'hA5A5_0000, 192'd0, 32'(k)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input logic r,
                       input logic [4:0] nb, input int k);
    @(negedge clk);
    in_valid  = v;
    in_sop    = s;
    in_eop    = e;
    in_err    = r;
    in_nbytes = nb;
    in_data   = beat_data(k);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    srst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    srst = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [4:0] nb, input int err_beat);
    for (int i = 1; i <= n; i++)
      drive(1'b1, i == 1, i == n, i == err_beat, (i == n) ? nb : 5'd0, i);
    idle(3);
  endtask

  int w0, d0;

  initial begin
    // Reset values
    do_reset();
    chk("rst_wrreq", 64'(fifo_wrreq), 64'd0);
    chk("rst_fdata", 64'(fifo_data), 64'd0);
    chk("rst_desc_wrreq", 64'(desc_wrreq), 64'd0);
    chk("rst_desc_data", 64'(desc_data), 64'd0);
    chk("rst_frames", 64'(stat_frames), 64'd0);
    chk("rst_drops", 64'(stat_drops), 64'd0);

    // 3-beat frame, 4 bytes in last beat: one-cycle latency, len = 68
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2);
    chk("t1_wr1", 64'(fifo_wrreq), 64'd1);
    chk("t1_d1", 64'(fifo_data[31:0]), 64'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 3);
    chk("t1_wr2", 64'(fifo_wrreq), 64'd1);
    chk("t1_d2", 64'(fifo_data[31:0]), 64'd2);
    chk("t1_desc_early", 64'(desc_wrreq), 64'd0);
    idle(1);
    chk("t1_wr3", 64'(fifo_wrreq), 64'd1);
    chk("t1_d3_hi", 64'(fifo_data[255:224]), 64'(32'd3 ^ 32'hA5A5_0000));
    chk("t1_desc_v", 64'(desc_wrreq), 64'd1);
    chk("t1_desc", 64'(desc_data), 64'd68);
    idle(1);
    chk("t1_wr_idle", 64'(fifo_wrreq), 64'd0);
    chk("t1_desc_idle", 64'(desc_wrreq), 64'd0);
    chk("t1_frames", 64'(stat_frames), 64'd1);

    // Admission threshold: 3796 + 301 > 4096 drops, 3795 + 301 = 4096 admits
    do_reset();
    w0 = wr_total; d0 = descq.size();
    fifo_wrusedw = 13'd3796;
    send_frame(2, 5'd10, 0);
    chk("t2_drop_writes", 64'(wr_total - w0), 64'd0);
    chk("t2_drops", 64'(stat_drops), 64'd1);
    fifo_wrusedw = 13'd3795;
    send_frame(2, 5'd10, 0);
    chk("t2_writes", 64'(wr_total - w0), 64'd2);
    chk("t2_ndesc", 64'(descq.size() - d0), 64'd1);
    chk("t2_desc", 64'(descq[d0]), 64'd42);
    chk("t2_frames", 64'(stat_frames), 64'd1);
    chk("t2_drops_end", 64'(stat_drops), 64'd1);
    fifo_wrusedw = '0;

    // Descriptor FIFO full at sop: 5-beat frame dropped whole
    do_reset();
    w0 = wr_total; d0 = descq.size();
    desc_full = 1'b1;
    send_frame(5, 5'd1, 0);
    desc_full = 1'b0;
    chk("t3_writes", 64'(wr_total - w0), 64'd0);
    chk("t3_ndesc", 64'(descq.size() - d0), 64'd0);
    chk("t3_drops", 64'(stat_drops), 64'd1);
    chk("t3_frames", 64'(stat_frames), 64'd0);

    // 310-beat frame with error on beat 2: truncated at 300 words
    do_reset();
    w0 = wr_total; d0 = descq.size();
    send_frame(310, 5'd7, 2);
    chk("t4_writes", 64'(wr_total - w0), 64'd300);
    chk("t4_ndesc", 64'(descq.size() - d0), 64'd1);
    chk("t4_desc", 64'(descq[d0]), 64'hE580);
    chk("t4_frames", 64'(stat_frames), 64'd1);

    // Exactly 300 beats, full last beat: not truncated, len = 9600
    w0 = wr_total; d0 = descq.size();
    send_frame(300, 5'd0, 0);
    chk("t4b_writes", 64'(wr_total - w0), 64'd300);
    chk("t4b_desc", 64'(descq[d0]), 64'h2580);
    chk("t4b_frames", 64'(stat_frames), 64'd2);

    // Missing eop: sop on beat 4 closes the old frame, new 1-beat frame follows
    do_reset();
    w0 = wr_total; d0 = descq.size();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 3);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 4);
    idle(1);
    chk("t5_close_v", 64'(desc_wrreq), 64'd1);
    chk("t5_close", 64'(desc_data), 64'h8060);
    chk("t5_new_wr", 64'(fifo_wrreq), 64'd1);
    chk("t5_new_data", 64'(fifo_data[31:0]), 64'd4);
    idle(1);
    chk("t5_second_v", 64'(desc_wrreq), 64'd1);
    chk("t5_second", 64'(desc_data), 64'd32);
    idle(2);
    chk("t5_writes", 64'(wr_total - w0), 64'd4);
    chk("t5_ndesc", 64'(descq.size() - d0), 64'd2);
    chk("t5_frames", 64'(stat_frames), 64'd2);

    // Single-beat frames: dropped while desc full, then admitted with error
    d0 = descq.size();
    desc_full = 1'b1;
    send_frame(1, 5'd3, 0);
    desc_full = 1'b0;
    send_frame(1, 5'd7, 1);
    chk("t5b_drops", 64'(stat_drops), 64'd1);
    chk("t5b_ndesc", 64'(descq.size() - d0), 64'd1);
    chk("t5b_desc", 64'(descq[d0]), 64'h8007);
    chk("t5b_frames", 64'(stat_frames), 64'd3);

    // Reset on beat 2 of a 4-beat frame: everything cleared, tail ignored
    do_reset();
    w0 = wr_total; d0 = descq.size();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2);
    srst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 3);
    srst = 1'b0;
    chk("t6_wrreq", 64'(fifo_wrreq), 64'd0);
    chk("t6_fdata", 64'(fifo_data[31:0]), 64'd0);
    chk("t6_desc_v", 64'(desc_wrreq), 64'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 4);
    idle(3);
    chk("t6_writes", 64'(wr_total - w0), 64'd1);
    chk("t6_ndesc", 64'(descq.size() - d0), 64'd0);
    chk("t6_frames", 64'(stat_frames), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
